// File: rtl/merge_pass_param.sv
`default_nettype none
// ============================================================================
// Module      : merge_pass_param
// Description : One merge pass. Merges adjacent sorted runs of length
//               2^run_log2 from src into runs twice as long in dst.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_pass_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [4:0]        run_log2,
    input  logic              mode_desc,
    input  logic              mode_signed,
    output logic [ADDR_W-1:0] src_address0,
    output logic              src_ce0,
    input  logic [DATA_W-1:0] src_q0,
    output logic [ADDR_W-1:0] src_address1,
    output logic              src_ce1,
    input  logic [DATA_W-1:0] src_q1,
    output logic [ADDR_W-1:0] dst_address0,
    output logic              dst_ce0,
    output logic              dst_we0,
    output logic [DATA_W-1:0] dst_d0
);

    localparam int PW = ADDR_W + 1;
    localparam int WW = ADDR_W + 2;

    localparam logic [PW-1:0] c_N        = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [4:0]    c_ADDR_W5  = 5'(ADDR_W);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_READ  = 2'd1;
    localparam logic [1:0] c_S_WRITE = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_a_ptr, r_a_end, r_b_ptr, r_b_end, r_out_idx, r_run_len;
    logic          r_desc, r_signed, r_done;

    function automatic logic [PW-1:0] clamp_n(input logic [WW-1:0] v);
        return (v > {1'b0, c_N}) ? c_N : v[PW-1:0];
    endfunction

    logic          w_in_read, w_in_write, w_last, w_accept;
    logic          w_a_valid, w_b_valid, w_a_le_b, w_a_ge_b, w_take_a;
    logic          w_pair_done;
    logic [PW-1:0] w_run_len, w_init_b_end, w_a_nxt, w_b_nxt, w_na_end, w_nb_end;

    assign w_in_read  = (r_state == c_S_READ);
    assign w_in_write = (r_state == c_S_WRITE);
    assign w_last     = w_in_read && (r_out_idx == c_N);
    assign w_accept   = (r_state == c_S_IDLE) && ap_start && !r_done;

    // Run lengths at or beyond N collapse to a single run: plain copy.
    assign w_run_len    = (run_log2 >= c_ADDR_W5) ? c_N : (c_ONE << run_log2);
    assign w_init_b_end = clamp_n({1'b0, w_run_len} + {1'b0, w_run_len});

    assign w_a_valid = (r_a_ptr < r_a_end);
    assign w_b_valid = (r_b_ptr < r_b_end);
    assign w_a_le_b  = r_signed ? ($signed(src_q0) <= $signed(src_q1)) : (src_q0 <= src_q1);
    assign w_a_ge_b  = r_signed ? ($signed(src_q0) >= $signed(src_q1)) : (src_q0 >= src_q1);
    // Equal keys resolve toward run A so the merge stays stable.
    assign w_take_a  = w_a_valid && (!w_b_valid || (r_desc ? w_a_ge_b : w_a_le_b));

    assign w_a_nxt     = r_a_ptr + {{ADDR_W{1'b0}}, w_take_a};
    assign w_b_nxt     = r_b_ptr + {{ADDR_W{1'b0}}, !w_take_a};
    assign w_pair_done = (w_a_nxt >= r_a_end) && (w_b_nxt >= r_b_end);
    assign w_na_end    = clamp_n({1'b0, r_b_end} + {1'b0, r_run_len});
    assign w_nb_end    = clamp_n({1'b0, w_na_end} + {1'b0, r_run_len});

    assign ap_done  = w_last || r_done;
    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == c_S_IDLE) && !ap_start;

    assign src_ce0      = w_in_read && (r_out_idx != c_N);
    assign src_ce1      = src_ce0;
    assign src_address0 = src_ce0 ? r_a_ptr[ADDR_W-1:0] : '0;
    assign src_address1 = src_ce1 ? r_b_ptr[ADDR_W-1:0] : '0;

    assign dst_ce0      = w_in_write;
    assign dst_we0      = w_in_write;
    assign dst_address0 = w_in_write ? r_out_idx[ADDR_W-1:0] : '0;
    assign dst_d0       = w_in_write ? (w_take_a ? src_q0 : src_q1) : '0;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state   <= c_S_IDLE;
            r_a_ptr   <= '0;
            r_a_end   <= '0;
            r_b_ptr   <= '0;
            r_b_end   <= '0;
            r_out_idx <= '0;
            r_run_len <= '0;
            r_desc    <= 1'b0;
            r_signed  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (ap_continue) begin
                r_done <= 1'b0;
            end else if (w_last) begin
                r_done <= 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_desc    <= mode_desc;
                        r_signed  <= mode_signed;
                        r_run_len <= w_run_len;
                        r_a_ptr   <= '0;
                        r_a_end   <= w_run_len;
                        r_b_ptr   <= w_run_len;
                        r_b_end   <= w_init_b_end;
                        r_out_idx <= '0;
                        r_state   <= c_S_READ;
                    end
                end
                c_S_READ: begin
                    r_state <= w_last ? c_S_IDLE : c_S_WRITE;
                end
                c_S_WRITE: begin
                    r_out_idx <= r_out_idx + c_ONE;
                    if (w_pair_done) begin
                        r_a_ptr <= r_b_end;
                        r_a_end <= w_na_end;
                        r_b_ptr <= w_na_end;
                        r_b_end <= w_nb_end;
                    end else begin
                        r_a_ptr <= w_a_nxt;
                        r_b_ptr <= w_b_nxt;
                    end
                    r_state <= c_S_READ;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
